// File: rtl/hept_stage_sequencer.sv
// hept_stage_sequencer: runs NUM_STAGES ap_ctrl_hs sub-kernels strictly in
// order behind one ap_ctrl_chain interface, recording per-stage latency and
// guarding every stage with an optional watchdog.
module hept_stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 0,
  localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic                  ap_continue,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [IDX_W-1:0]      cur_stage,
  input  logic [IDX_W-1:0]      lat_sel,
  output logic [CNT_W-1:0]      lat_out,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);
  // Timeout fires in the cycle whose count would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic             TO_ENABLE  = (TIMEOUT > 0);

  state_t                       state_reg, state_next;
  logic [IDX_W-1:0]             cur_reg, cur_next;
  logic                         ready_seen_reg, ready_seen_next;
  logic                         ap_ready_reg, ap_ready_next;
  logic                         err_reg, err_next;
  logic [CNT_W-1:0]             lat_reg [NUM_STAGES];
  logic [NUM_STAGES-1:0][CNT_W-1:0] lat_next;

  logic             cur_ready;
  logic             cur_done;
  logic [CNT_W-1:0] lat_cur;
  logic             timeout_hit;
  logic             stage_enter;
  logic             lat_tick;
  logic             sel_in_range;

  assign cur_ready   = stage_ready[cur_reg];
  assign cur_done    = stage_done[cur_reg];
  assign lat_cur     = lat_reg[cur_reg];
  assign timeout_hit = TO_ENABLE && (lat_cur == TO_LIMIT);

  // State register and sequencing flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cur_reg        <= '0;
      ready_seen_reg <= 1'b0;
      ap_ready_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      ready_seen_reg <= ready_seen_next;
      ap_ready_reg   <= ap_ready_next;
      err_reg        <= err_next;
    end
  end

  // Next-state logic: in-order stage walk, done beats a coincident timeout.
  always_comb begin
    state_next      = state_reg;
    cur_next        = cur_reg;
    ready_seen_next = ready_seen_reg;
    ap_ready_next   = 1'b0;
    err_next        = err_reg;
    stage_enter     = 1'b0;
    lat_tick        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ap_start) begin
          state_next      = S_RUN;
          cur_next        = '0;
          ready_seen_next = 1'b0;
          stage_enter     = 1'b1;
        end
      end
      S_RUN: begin
        lat_tick = 1'b1;
        if (cur_ready && !ready_seen_reg) begin
          ready_seen_next = 1'b1;
          if (cur_reg == '0) begin
            ap_ready_next = 1'b1;
          end
        end
        if (cur_done) begin
          if (cur_reg == LAST_STAGE) begin
            state_next = S_DONE;
          end else begin
            cur_next        = cur_reg + IDX_W'(1);
            ready_seen_next = 1'b0;
            stage_enter     = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = S_ERR;
          err_next   = 1'b1;
        end
      end
      S_DONE: begin
        if (ap_continue) begin
          state_next = S_IDLE;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-stage start strobe and latency next-value: clear on entry, count
  // every RUN cycle of the owning stage, saturate at all-ones.
  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign stage_start[gi] = (state_reg == S_RUN) && (cur_reg == IDX_W'(gi)) && !ready_seen_reg;
      assign lat_next[gi] =
          (stage_enter && (cur_next == IDX_W'(gi))) ? '0 :
          (lat_tick && (cur_reg == IDX_W'(gi)) && (lat_reg[gi] != '1)) ? lat_reg[gi] + CNT_W'(1) :
          lat_reg[gi];
    end
  endgenerate

  // Latency register bank.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (reset) begin
        lat_reg[i] <= '0;
      end else begin
        lat_reg[i] <= lat_next[i];
      end
    end
  end

  // Combinational latency readback; out-of-range selects read as zero.
  always_comb begin
    sel_in_range = (32'(lat_sel) < NUM_STAGES);
    lat_out      = sel_in_range ? lat_reg[lat_sel] : '0;
  end

  assign ap_ready    = ap_ready_reg;
  assign ap_done     = (state_reg == S_DONE);
  assign ap_idle     = (state_reg == S_IDLE);
  assign cur_stage   = cur_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_hept_stage_sequencer.sv
// tb_hept_stage_sequencer: two 3-stage sequencers (watchdog off / TIMEOUT=8)
// driven by behavioural sub-kernel stubs; runs are scoreboarded by latency.
module tb_hept_stage_sequencer;

  logic       clock;
  logic       reset_s       [2];
  logic       ap_start_s    [2];
  logic       ap_continue_s [2];
  logic       ap_ready_s    [2];
  logic       ap_done_s     [2];
  logic       ap_idle_s     [2];
  logic       err_s         [2];
  logic [2:0] stage_start_s [2];
  logic [2:0] stage_ready_s [2];
  logic [2:0] stage_done_s  [2];
  logic [1:0] cur_s         [2];
  logic [1:0] lat_sel_s     [2];
  logic [31:0] lat_out_s    [2];

  int checks = 0;
  int failures = 0;

  // Stub configuration: done n-1 cycles after start rises, ready rd cycles after.
  int  stub_n     [2][3];
  int  stub_rd    [2][3];
  bit  stub_never [2][3];
  bit  stub_act   [2][3];
  int  stub_age   [2][3];

  typedef struct {
    int n0; int n1; int n2;
    int rd0;
    int cont;
    int exp_cyc;
    int exp_s0;
  } vec_t;

  typedef struct {
    int l0; int l1; int l2; int cyc;
  } exp_t;

  exp_t sb_q [$];

  hept_stage_sequencer #(.NUM_STAGES(3), .CNT_W(32), .TIMEOUT(0)) dut0 (
    .clock(clock), .reset(reset_s[0]),
    .ap_start(ap_start_s[0]), .ap_continue(ap_continue_s[0]),
    .ap_ready(ap_ready_s[0]), .ap_done(ap_done_s[0]), .ap_idle(ap_idle_s[0]),
    .stage_start(stage_start_s[0]), .stage_ready(stage_ready_s[0]),
    .stage_done(stage_done_s[0]), .cur_stage(cur_s[0]),
    .lat_sel(lat_sel_s[0]), .lat_out(lat_out_s[0]), .err_timeout(err_s[0])
  );

  hept_stage_sequencer #(.NUM_STAGES(3), .CNT_W(32), .TIMEOUT(8)) dut1 (
    .clock(clock), .reset(reset_s[1]),
    .ap_start(ap_start_s[1]), .ap_continue(ap_continue_s[1]),
    .ap_ready(ap_ready_s[1]), .ap_done(ap_done_s[1]), .ap_idle(ap_idle_s[1]),
    .stage_start(stage_start_s[1]), .stage_ready(stage_ready_s[1]),
    .stage_done(stage_done_s[1]), .cur_stage(cur_s[1]),
    .lat_sel(lat_sel_s[1]), .lat_out(lat_out_s[1]), .err_timeout(err_s[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sub-kernel stubs, updated on the falling edge.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        if (reset_s[d]) begin
          stub_act[d][i] = 1'b0;
          stage_ready_s[d][i] = 1'b0;
          stage_done_s[d][i] = 1'b0;
        end else begin
          if (!stub_act[d][i] && stage_start_s[d][i]) begin
            stub_act[d][i] = 1'b1;
            stub_age[d][i] = 0;
          end else if (stub_act[d][i]) begin
            stub_age[d][i] = stub_age[d][i] + 1;
          end
          stage_ready_s[d][i] = stub_act[d][i] && (stub_age[d][i] == stub_rd[d][i]);
          stage_done_s[d][i]  = stub_act[d][i] && !stub_never[d][i] &&
                                (stub_age[d][i] == stub_n[d][i] - 1);
          if (stage_done_s[d][i]) stub_act[d][i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic chk_lats(input int d, input int e0, input int e1, input int e2, input string tag);
    lat_sel_s[d] = 2'd0; #1; chk({tag, "_lat0"}, lat_out_s[d], e0);
    lat_sel_s[d] = 2'd1; #1; chk({tag, "_lat1"}, lat_out_s[d], e1);
    lat_sel_s[d] = 2'd2; #1; chk({tag, "_lat2"}, lat_out_s[d], e2);
  endtask

  task automatic set_stubs(input int d, input int n0, input int n1, input int n2, input int rd0);
    stub_n[d][0] = n0; stub_n[d][1] = n1; stub_n[d][2] = n2;
    stub_rd[d][0] = rd0; stub_rd[d][1] = 0; stub_rd[d][2] = 0;
    for (int i = 0; i < 3; i++) stub_never[d][i] = 1'b0;
  endtask

  task automatic run_row(input int d, input vec_t v, input int row);
    int   cyc;
    int   s0_hi;
    int   rdy_cnt;
    int   dcnt;
    bit   prev_d0;
    bit   prev_r0;
    exp_t e;
    set_stubs(d, v.n0, v.n1, v.n2, v.rd0);
    tick();
    ap_start_s[d] = 1'b1;
    ap_continue_s[d] = (v.cont == 0);
    @(posedge clock);
    e.l0 = v.n0; e.l1 = v.n1; e.l2 = v.n2; e.cyc = v.exp_cyc;
    sb_q.push_back(e);
    cyc = 0; s0_hi = 0; rdy_cnt = 0; prev_d0 = 0; prev_r0 = 0;
    tick();
    ap_start_s[d] = 1'b0;
    chk("first_start", stage_start_s[d], 3'b001);
    chk("busy_not_idle", ap_idle_s[d], 0);
    while (!ap_done_s[d] && cyc < 200) begin
      s0_hi += int'(stage_start_s[d][0]);
      rdy_cnt += int'(ap_ready_s[d]);
      if (prev_r0) chk("ap_ready_after_ready", ap_ready_s[d], 1);
      if (prev_d0) chk("start1_after_done0", stage_start_s[d], 3'b010);
      prev_r0 = stage_ready_s[d][0] && (cur_s[d] == 2'd0);
      prev_d0 = stage_done_s[d][0] && (cur_s[d] == 2'd0);
      tick();
      cyc++;
    end
    chk("done_reached", ap_done_s[d], 1);
    chk("stage0_hold", s0_hi, v.exp_s0);
    chk("ready_pulses", rdy_cnt, 1);
    chk("done_cur_stage", cur_s[d], 2);
    chk("done_no_start", stage_start_s[d], 0);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("run_cycles", cyc, e.cyc);
      chk_lats(d, e.l0, e.l1, e.l2, "run");
    end
    dcnt = 1;
    if (v.cont != 0) begin
      ap_start_s[d] = 1'b1;
      repeat (v.cont - 1) begin
        tick();
        dcnt += int'(ap_done_s[d]);
      end
      chk("done_held", dcnt, v.cont);
      ap_continue_s[d] = 1'b1;
      ap_start_s[d] = 1'b0;
    end
    tick();
    chk("idle_after_cont", ap_idle_s[d], 1);
    chk("done_dropped", ap_done_s[d], 0);
    ap_continue_s[d] = 1'b0;
    tick();
    chk("stays_idle", ap_idle_s[d], 1);
    $display("run dut=%0d row=%0d cycles=%0d s0_hold=%0d done_cycles=%0d", d, row, cyc, s0_hi, dcnt);
  endtask

  vec_t vecs [6];
  int   cyc;

  initial begin
    vecs[0] = '{n0:5, n1:10, n2:3, rd0:0, cont:1, exp_cyc:18, exp_s0:1};
    vecs[1] = '{n0:5, n1:10, n2:3, rd0:3, cont:2, exp_cyc:18, exp_s0:4};
    vecs[2] = '{n0:5, n1:10, n2:3, rd0:0, cont:7, exp_cyc:18, exp_s0:1};
    vecs[3] = '{n0:1, n1:1,  n2:1, rd0:0, cont:0, exp_cyc:3,  exp_s0:1};
    vecs[4] = '{n0:2, n1:7,  n2:4, rd0:1, cont:3, exp_cyc:13, exp_s0:2};
    vecs[5] = '{n0:8, n1:2,  n2:6, rd0:2, cont:0, exp_cyc:16, exp_s0:3};

    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1; ap_start_s[d] = 1'b0; ap_continue_s[d] = 1'b0; lat_sel_s[d] = 2'd0;
      set_stubs(d, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
        stub_act[d][i] = 1'b0; stub_age[d][i] = 0;
      end
      stage_ready_s[d] = 3'b000; stage_done_s[d] = 3'b000;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_start", stage_start_s[d], 0);
      chk("rst_ready", ap_ready_s[d], 0);
      chk("rst_done", ap_done_s[d], 0);
      chk("rst_idle", ap_idle_s[d], 1);
      chk("rst_cur", cur_s[d], 0);
      chk("rst_err", err_s[d], 0);
      chk_lats(d, 0, 0, 0, "rst");
      $display("reset check dut=%0d", d);
    end
    reset_s[0] = 1'b0; reset_s[1] = 1'b0;
    tick();

    for (int r = 0; r < 6; r++) run_row(0, vecs[r], r);

    // Reset while stage 2 is running, then a fresh run.
    set_stubs(0, 5, 10, 3, 0);
    tick();
    ap_start_s[0] = 1'b1;
    tick();
    ap_start_s[0] = 1'b0;
    cyc = 0;
    while (cur_s[0] != 2'd2 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reach_stage2", cur_s[0], 2);
    tick();
    reset_s[0] = 1'b1;
    tick();
    chk("midrst_start", stage_start_s[0], 0);
    chk("midrst_idle", ap_idle_s[0], 1);
    chk("midrst_cur", cur_s[0], 0);
    chk("midrst_done", ap_done_s[0], 0);
    chk_lats(0, 0, 0, 0, "midrst");
    $display("mid-run reset dut=0 stage2_reached_after=%0d", cyc);
    tick();
    reset_s[0] = 1'b0;
    tick();
    run_row(0, vecs[0], 100);

    // Watchdog: stage 1 never completes.
    set_stubs(1, 3, 1, 2, 0);
    stub_never[1][1] = 1'b1;
    tick();
    ap_start_s[1] = 1'b1;
    tick();
    ap_start_s[1] = 1'b0;
    cyc = 0;
    while (!err_s[1] && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("err_raised", err_s[1], 1);
    chk("err_cycle", cyc, 11);
    chk("err_start", stage_start_s[1], 0);
    chk("err_done", ap_done_s[1], 0);
    chk("err_idle", ap_idle_s[1], 0);
    lat_sel_s[1] = 2'd1; #1; chk("err_lat1", lat_out_s[1], 8);
    lat_sel_s[1] = 2'd0; #1; chk("err_lat0", lat_out_s[1], 3);
    $display("watchdog dut=1 err_cycle=%0d", cyc);
    ap_start_s[1] = 1'b1;
    ap_continue_s[1] = 1'b1;
    repeat (5) tick();
    chk("err_sticky", err_s[1], 1);
    chk("err_hold_idle", ap_idle_s[1], 0);
    chk("err_hold_start", stage_start_s[1], 0);
    chk("err_hold_done", ap_done_s[1], 0);
    ap_start_s[1] = 1'b0;
    ap_continue_s[1] = 1'b0;
    reset_s[1] = 1'b1;
    tick();
    chk("err_rst_err", err_s[1], 0);
    chk("err_rst_idle", ap_idle_s[1], 1);
    chk_lats(1, 0, 0, 0, "err_rst");
    $display("watchdog reset dut=1");
    tick();
    reset_s[1] = 1'b0;
    tick();

    // Every stage finishes exactly at the watchdog limit.
    run_row(1, '{n0:8, n1:8, n2:8, rd0:0, cont:1, exp_cyc:24, exp_s0:1}, 200);
    chk("edge_no_err", err_s[1], 0);
    run_row(1, vecs[4], 201);
    chk("edge2_no_err", err_s[1], 0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/hept_stage_sequencer.md
Name: hept_stage_sequencer

Overview:
Top-level control sequencer for the HEPT attention pipeline. It runs NUM_STAGES HLS sub-kernels (e.g. qk_einsum, add_clamp_exp, normalisation, output einsum) strictly in order using ap_ctrl_hs handshakes, and exposes a single ap_ctrl_chain interface upward. It also records per-stage latency and guards each stage with a watchdog. The existing module-status monitors observe its ap_start/ap_ready/ap_done at the top level.

Parameters:
NUM_STAGES, 4, number of sequenced sub-kernels (2..16).
CNT_W, 32, width of the per-stage latency counters (saturating).
TIMEOUT, 0, per-stage watchdog limit in cycles; 0 disables the watchdog.

Ports:
clock  in  1  single clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
ap_start  in  1  request one pipeline run.
ap_continue  in  1  upstream acknowledgement of ap_done.
ap_ready  out  1  one-cycle pulse when stage 0 has accepted its input.
ap_done  out  1  run complete; held until ap_continue.
ap_idle  out  1  high only in IDLE.
stage_start  out  NUM_STAGES  ap_start to each sub-kernel, one-hot or zero.
stage_ready  in  NUM_STAGES  ap_ready from each sub-kernel.
stage_done  in  NUM_STAGES  ap_done from each sub-kernel.
cur_stage  out  IDX_W  index of the active stage; IDX_W = max(1, clog2(NUM_STAGES)).
lat_sel  in  IDX_W  selects the stage latency to read.
lat_out  out  CNT_W  latency of the selected stage from the last run (combinational read).
err_timeout  out  1  sticky watchdog error flag.

Behaviour:
- Reset values: stage_start=0, ap_ready=0, ap_done=0, ap_idle=1, cur_stage=0, err_timeout=0, all latency registers=0, FSM=IDLE.
- States: IDLE, RUN, DONE, ERR.
- IDLE:
  - ap_start=1 → RUN with cur_stage=0. stage_start[0] goes high the next cycle.
  - Latency registers are not cleared here. Each stage clears its own register on entry.
- RUN, stage i:
  - stage_start[i] stays high until stage_ready[i] is seen. It drops the cycle after the ready cycle.
  - A ready_seen flag latches stage_ready[i].
  - lat[i] clears on stage entry and increments every RUN cycle of stage i, including the cycle in which done is seen. It saturates at all-ones.
  - Advance when stage_done[i]=1. If stage_ready[i] and stage_done[i] arrive in the same cycle, treat both as seen.
  - On done at cycle t: if i<NUM_STAGES-1, cur_stage=i+1 and stage_start[i+1]=1 at t+1. Zero bubble cycles between stages.
  - On done of the last stage: go to DONE at t+1.
  - Example: a sub-kernel with done 4 cycles after the start rises gives lat=5.
- ap_ready pulses for exactly one cycle: the cycle after stage_ready[0] is observed during stage 0.
- ap_start is ignored outside IDLE. A new run needs ap_start high in IDLE.
- DONE:
  - ap_done=1, all stage_start=0, cur_stage holds NUM_STAGES-1.
  - ap_continue=1 → IDLE next cycle. If ap_start is also high in that IDLE cycle, the next run begins normally.
  - ap_continue already high on DONE entry → exactly one ap_done cycle.
- Watchdog (TIMEOUT>0):
  - When lat[i] reaches TIMEOUT without done: go to ERR and set err_timeout=1.
  - In ERR: stage_start=0, ap_done=0, ap_idle=0. Only reset exits ERR.
  - A done arriving in the same cycle as the timeout wins; no error is raised.
- Spurious stage_done/stage_ready on non-active stages are ignored.
- Reset mid-run: all outputs return to reset values on the next edge. In-flight sub-kernel state is the sub-kernels' own concern.

Test Plan:
- NUM_STAGES=3, stub latencies 5/10/3 (done N-1 cycles after start), ready coincident with start:
  - stage_start[1] rises the cycle after stage_done[0].
  - ap_done is asserted 18 cycles after ap_start is sampled.
  - lat_out = 5/10/3 for lat_sel = 0/1/2.
- Stage 0 stub delays stage_ready 3 cycles:
  - stage_start[0] is held 4 cycles.
  - ap_ready pulses once, one cycle after the ready.
- ap_continue held 0 for 7 cycles after done:
  - ap_done stays high 7 cycles and ap_start pulses are ignored.
  - On ap_continue=1, IDLE the next cycle and ap_idle=1.
- TIMEOUT=8, stage 1 never asserts done:
  - err_timeout=1 when lat[1]=8, stage_start=0.
  - The state holds until reset, which clears everything.
- TIMEOUT=8, stage done exactly at lat=8 → no error and the run completes.
- Reset asserted during stage 2 → next cycle stage_start=0, ap_idle=1, latencies=0; a fresh run then completes normally.
